// File: rtl/sub_multiword_serial_if.sv
// Streaming word interface for the multi-word serial subtractor.
// The slave side is the subtractor; the master side feeds operands and consumes results.
interface sub_multiword_serial_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_diff;
  logic        out_borrow;
  logic        out_first;
  logic        out_last;
  logic        out_zero;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_diff, out_borrow, out_first, out_last, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_diff, out_borrow, out_first, out_last, out_zero
  );
endinterface

// File: rtl/sub_multiword_serial.sv
// Serial WORDS*32-bit unsigned subtractor, least significant word first, with a
// registered inter-word borrow chain and a whole-operand equality flag.
module sub_multiword_serial #(
  parameter int unsigned WORDS = 4
) (
  input logic                  clk,
  input logic                  rst,
  sub_multiword_serial_if.slave bus
);
  localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            borrow_reg;
  logic            zero_acc;

  logic        accept;
  logic        borrow_in;
  logic        is_last;
  logic        zero_next;
  logic [32:0] wide;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // IDLE is exactly idx==0, so word 0 never sees a stale borrow or zero history.
  always_comb begin
    borrow_in = (state == ACTIVE) ? borrow_reg : 1'b0;
    wide      = {1'b0, bus.in_a} - {1'b0, bus.in_b} - {32'd0, borrow_in};
    is_last   = (idx == LAST_IDX);
    zero_next = ((state == IDLE) ? 1'b1 : zero_acc) & (wide[31:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_diff   <= '0;
      bus.out_borrow <= 1'b0;
      bus.out_first  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.out_zero   <= 1'b0;
      idx            <= '0;
      borrow_reg     <= 1'b0;
      zero_acc       <= 1'b1;
      state          <= IDLE;
    end else if (accept) begin
      bus.out_valid  <= 1'b1;
      bus.out_diff   <= wide[31:0];
      bus.out_borrow <= wide[32];
      bus.out_first  <= (state == IDLE);
      bus.out_last   <= is_last;
      bus.out_zero   <= is_last & zero_next;
      borrow_reg     <= wide[32];
      zero_acc       <= zero_next;
      if (is_last) begin
        idx   <= '0;
        state <= IDLE;
      end else begin
        idx   <= idx + IDXW'(1);
        state <= ACTIVE;
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sub_multiword_serial.sv
// Bench for sub_multiword_serial: a WORDS=2 instance for directed cases and a
// WORDS=4 instance for randomized streaming, both checked against a wide-arithmetic model.
module tb_sub_multiword_serial;
  typedef struct packed {
    logic [31:0] diff;
    logic        borrow;
    logic        first;
    logic        last;
    logic        zero;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rnd_on = 1'b0;
  int   tests = 0;
  int   fails = 0;
  beat_t q2[$];
  beat_t q4[$];

  always #5 clk = ~clk;

  sub_multiword_serial_if bus2();
  sub_multiword_serial_if bus4();

  sub_multiword_serial #(.WORDS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  sub_multiword_serial #(.WORDS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Word i of A-B over the whole operand; the borrow out of word i is just
  // the comparison of the low (i+1) words of A and B.
  function automatic beat_t model_beat(input int w, input logic [127:0] a, input logic [127:0] b, input int i);
    beat_t       r;
    logic [128:0] m;
    logic [127:0] d;
    m        = (129'd1 << (32 * (i + 1))) - 129'd1;
    d        = a - b;
    r.diff   = d[32*i +: 32];
    r.borrow = (({1'b0, a} & m) < ({1'b0, b} & m));
    r.first  = (i == 0);
    r.last   = (i == w - 1);
    r.zero   = (i == w - 1) && (a == b);
    return r;
  endfunction

  function automatic void push_exp(input int w, input logic [127:0] a, input logic [127:0] b);
    for (int i = 0; i < w; i++) begin
      if (w == 2) q2.push_back(model_beat(w, a, b, i));
      else        q4.push_back(model_beat(w, a, b, i));
    end
  endfunction

  function automatic beat_t dut_beat(input int sel);
    if (sel == 2) return {bus2.out_diff, bus2.out_borrow, bus2.out_first, bus2.out_last, bus2.out_zero};
    return {bus4.out_diff, bus4.out_borrow, bus4.out_first, bus4.out_last, bus4.out_zero};
  endfunction

  function automatic logic rdy(input int sel);
    return (sel == 2) ? bus2.in_ready : bus4.in_ready;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (sel == 2) begin
      bus2.in_valid = v; bus2.in_a = a; bus2.in_b = b;
    end else begin
      bus4.in_valid = v; bus4.in_a = a; bus4.in_b = b;
    end
  endtask

  task automatic wait_accept(input int sel);
    int   n = 0;
    logic acc = 1'b0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = rdy(sel);
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_op(input int sel, input logic [127:0] a, input logic [127:0] b,
                         input int gap_max, input int nwords);
    push_exp(sel, a, b);
    for (int i = 0; i < nwords; i++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      set_in(sel, 1'b1, a[32*i +: 32], b[32*i +: 32]);
      wait_accept(sel);
      set_in(sel, 1'b0, '0, '0);
    end
  endtask

  task automatic cmp(input int sel);
    beat_t e;
    if (sel == 2) begin
      if (q2.size() == 0) begin chk("extra_word_w2", 64'd1, 64'd0); return; end
      e = q2.pop_front();
      chk("beat_w2", 64'(dut_beat(2)), 64'(e));
    end else begin
      if (q4.size() == 0) begin chk("extra_word_w4", 64'd1, 64'd0); return; end
      e = q4.pop_front();
      chk("beat_w4", 64'(dut_beat(4)), 64'(e));
    end
  endtask

  function automatic logic [31:0] rword();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    beat_t       snap;
    logic [127:0] ra, rb;
    int          n;

    set_in(2, 1'b0, '0, '0);
    set_in(4, 1'b0, '0, '0);
    bus2.out_ready = 1'b1;
    bus4.out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          q2.delete();
          q4.delete();
        end else begin
          if (bus2.out_valid && bus2.out_ready) cmp(2);
          if (bus4.out_valid && bus4.out_ready) cmp(4);
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_w2", 64'(bus2.out_valid), 64'd0);
    chk("rst_beat_w2", 64'(dut_beat(2)), 64'd0);
    chk("rst_in_ready_w2", 64'(bus2.in_ready), 64'd1);
    chk("rst_valid_w4", 64'(bus4.out_valid), 64'd0);
    chk("rst_beat_w4", 64'(dut_beat(4)), 64'd0);
    rst = 1'b0;

    // Hand-computed pins on the model.
    chk("pin_chain_0", 64'(model_beat(2, 128'h1_00000000, 128'h1, 0)), 64'({32'hFFFFFFFF, 4'b1100}));
    chk("pin_chain_1", 64'(model_beat(2, 128'h1_00000000, 128'h1, 1)), 64'({32'h0, 4'b0010}));
    chk("pin_equal_1", 64'(model_beat(2, 128'h9ABCDEF0_12345678, 128'h9ABCDEF0_12345678, 1)),
        64'({32'h0, 4'b0011}));
    chk("pin_wrap_1", 64'(model_beat(2, 128'h0, 128'h1, 1)), 64'({32'hFFFFFFFF, 4'b1010}));
    chk("pin_maxb_1", 64'(model_beat(2, 128'h0, 128'hFFFFFFFF_00000001, 1)), 64'({32'h0, 4'b1010}));
    chk("pin_after_rst", 64'(model_beat(2, 128'h5, 128'h3, 0)), 64'({32'h2, 4'b0100}));

    send_op(2, 128'h1_00000000, 128'h1, 0, 2);
    send_op(2, 128'h9ABCDEF0_12345678, 128'h9ABCDEF0_12345678, 2, 2);
    send_op(2, 128'h0, 128'h1, 0, 2);
    send_op(2, 128'h0, 128'hFFFFFFFF_00000001, 3, 2);
    repeat (3) begin @(posedge clk); #1; end

    // Backpressure: word 1 must stall while word 0 sits unconsumed.
    push_exp(2, 128'h22_00000011, 128'h30_00000001);
    bus2.out_ready = 1'b0;
    set_in(2, 1'b1, 32'h11, 32'h1);
    wait_accept(2);
    snap = dut_beat(2);
    set_in(2, 1'b1, 32'h22, 32'h30);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus2.in_ready), 64'd0);
      chk("bp_valid", 64'(bus2.out_valid), 64'd1);
      chk("bp_stable", 64'(dut_beat(2)), 64'(snap));
    end
    @(posedge clk);
    #1;
    bus2.out_ready = 1'b1;
    wait_accept(2);
    set_in(2, 1'b0, '0, '0);
    repeat (3) begin @(posedge clk); #1; end

    // Reset in the middle of an operand whose word 0 left a borrow pending.
    send_op(2, 128'h0, 128'h1, 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", 64'(bus2.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus2.in_ready), 64'd1);
    send_op(2, 128'h5, 128'h3, 0, 2);
    repeat (3) begin @(posedge clk); #1; end

    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          bus4.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus4.out_ready = 1'b1;
      end
    join_none
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < 4; i++) ra[32*i +: 32] = rword();
      if ($urandom_range(0, 3) == 0) rb = ra;
      else for (int i = 0; i < 4; i++) rb[32*i +: 32] = ($urandom_range(0, 1) != 0) ? ra[32*i +: 32] : rword();
      send_op(4, ra, rb, 2, 4);
    end
    rnd_on = 1'b0;

    n = 0;
    while ((q2.size() != 0 || q4.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    chk("drain_w2", 64'(q2.size()), 64'd0);
    chk("drain_w4", 64'(q4.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
